// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial chunk adder: FSM state encoding.
package serial_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry-in and carry-out.
module chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);
    assign sum   = total[CHUNK-1:0];
    assign cout  = total[CHUNK];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: adds CHUNK bits per clock through one shared chunk_adder,
// then presents the registered sum, carry-out and reductions with a done pulse.
module serial_chunk_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             and_out,
    output logic             or_out,
    output logic             xor_out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] next_partial;
    logic             run_carry;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             capture;

    // Operands are only latched when idle or finishing, so start is ignored mid-add.
    assign capture = start && (state != BUSY);

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (a_q[idx*CHUNK +: CHUNK]),
        .b    (b_q[idx*CHUNK +: CHUNK]),
        .cin  (run_carry),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        next_partial = partial;
        next_partial[idx*CHUNK +: CHUNK] = chunk_sum;
    end

    // NOTE: operand registers are pure datapath and carry no reset; they are always
    // rewritten on capture before they are ever used.
    always_ff @(posedge clk) begin
        if (capture) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            partial   <= '0;
            run_carry <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            and_out   <= 1'b0;
            or_out    <= 1'b0;
            xor_out   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= BUSY;
                        busy      <= 1'b1;
                        idx       <= '0;
                        partial   <= '0;
                        run_carry <= cin;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                BUSY: begin
                    partial   <= next_partial;
                    run_carry <= chunk_cout;
                    if (idx == LAST_IDX) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        sum     <= next_partial;
                        carry   <= chunk_cout;
                        and_out <= &next_partial;
                        or_out  <= |next_partial;
                        xor_out <= ^next_partial;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
